// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing a two-port 16x16 register file among N_REQ requesters.
// Port A serves reads only, port B serves one read or one write; an optional clear sweep zeroes r0..r15 after reset.

module rf_port_arbiter_resp (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        rd_grant_i,
    input  logic [15:0] rd_data_i,
    output logic        resp_valid_o,
    output logic [15:0] resp_rdata_o
);
    logic        valid_q;
    logic [15:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_grant_i) rdata_d = rd_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            valid_q <= rd_grant_i;
            rdata_q <= rdata_d;
        end
    end

    assign resp_valid_o = valid_q;
    assign resp_rdata_o = rdata_q;
endmodule

module rf_port_arbiter #(
    parameter int N_REQ          = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [N_REQ-1:0]      req_write_i,
    input  logic [4*N_REQ-1:0]    req_reg_i,
    input  logic [16*N_REQ-1:0]   req_wdata_i,
    output logic [N_REQ-1:0]      req_grant_o,
    output logic [N_REQ-1:0]      resp_valid_o,
    output logic [16*N_REQ-1:0]   resp_rdata_o,
    output logic                  init_done_o,
    output logic                  rf_rd1_o,
    output logic                  rf_wn1_o,
    output logic [3:0]            rf_reg_id1_o,
    output logic [15:0]           rf_write_data1_o,
    output logic                  rf_rd2_o,
    output logic                  rf_wn2_o,
    output logic [3:0]            rf_reg_id2_o,
    output logic [15:0]           rf_write_data2_o,
    input  logic [15:0]           rf_read_data1_i,
    input  logic [15:0]           rf_read_data2_i
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e             state_q, state_d;
    logic [3:0]         clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0][3:0]  req_reg;
    logic [N_REQ-1:0][15:0] req_wdata;
    logic [N_REQ-1:0][15:0] resp_rdata;
    logic [N_REQ-1:0][15:0] rd_data;

    logic [N_REQ-1:0] gnt, gnt_on_b, gnt_rd;
    logic             a_busy, b_busy, b_wr, any_gnt;
    logic [PTR_W-1:0] last, idx;
    logic [PTR_W:0]   sum;
    logic [3:0]       a_reg, b_reg;
    logic [15:0]      b_wdata;

    assign req_reg   = req_reg_i;
    assign req_wdata = req_wdata_i;

    // Rotating scan from rr_ptr; a blocked request never stops later requesters.
    always_comb begin
        gnt      = '0;
        gnt_on_b = '0;
        a_busy   = 1'b0;
        b_busy   = 1'b0;
        b_wr     = 1'b0;
        any_gnt  = 1'b0;
        last     = rr_ptr_q;
        idx      = '0;
        sum      = '0;
        a_reg    = '0;
        b_reg    = '0;
        b_wdata  = '0;
        if (reset_ni && state_q == RUN) begin
            for (int k = 0; k < N_REQ; k++) begin
                sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
                idx = sum[PTR_W-1:0];
                if (req_valid_i[idx]) begin
                    if (req_write_i[idx]) begin
                        if (!b_busy) begin
                            b_busy        = 1'b1;
                            b_wr          = 1'b1;
                            b_reg         = req_reg[idx];
                            b_wdata       = req_wdata[idx];
                            gnt[idx]      = 1'b1;
                            gnt_on_b[idx] = 1'b1;
                            last          = idx;
                            any_gnt       = 1'b1;
                        end
                    end else if (!a_busy) begin
                        a_busy   = 1'b1;
                        a_reg    = req_reg[idx];
                        gnt[idx] = 1'b1;
                        last     = idx;
                        any_gnt  = 1'b1;
                    end else if (!b_busy) begin
                        b_busy        = 1'b1;
                        b_reg         = req_reg[idx];
                        gnt[idx]      = 1'b1;
                        gnt_on_b[idx] = 1'b1;
                        last          = idx;
                        any_gnt       = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            if (last == PTR_W'(N_REQ-1)) rr_ptr_d = '0;
            else                          rr_ptr_d = last + PTR_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 4'd1;
            if (clr_cnt_q == 4'd15) state_d = RUN;
        end
    end

    // Without a clear sweep the reset state is already RUN, so service starts on the first cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        rf_rd1_o         = a_busy;
        rf_reg_id1_o     = a_reg;
        rf_rd2_o         = b_busy & ~b_wr;
        rf_wn2_o         = b_wr;
        rf_reg_id2_o     = b_reg;
        rf_write_data2_o = b_wdata;
        if (reset_ni && state_q == CLEAR) begin
            rf_rd2_o         = 1'b0;
            rf_wn2_o         = 1'b1;
            rf_reg_id2_o     = clr_cnt_q;
            rf_write_data2_o = '0;
        end
    end

    assign rf_wn1_o         = 1'b0;
    assign rf_write_data1_o = '0;
    assign req_grant_o      = gnt;
    assign gnt_rd           = gnt & ~req_write_i;
    assign init_done_o      = reset_ni && (state_q == RUN);

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_resp
            assign rd_data[g] = gnt_on_b[g] ? rf_read_data2_i : rf_read_data1_i;
            rf_port_arbiter_resp u_resp (
                .clk_i        (clk_i),
                .reset_ni     (reset_ni),
                .rd_grant_i   (gnt_rd[g]),
                .rd_data_i    (rd_data[g]),
                .resp_valid_o (resp_valid_o[g]),
                .resp_rdata_o (resp_rdata[g])
            );
        end
    endgenerate

    assign resp_rdata_o = resp_rdata;
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomized and directed bench for rf_port_arbiter with a scoreboard of expected read responses
// and a register-file model driven by the DUT's port strobes.

module tb_rf_port_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic [N-1:0]       req_valid, req_write, req_grant, resp_valid;
    logic [N-1:0][3:0]  req_reg;
    logic [N-1:0][15:0] req_wdata, resp_rdata;
    logic init_done;
    logic rf_rd1, rf_wn1, rf_rd2, rf_wn2;
    logic [3:0]  rf_reg_id1, rf_reg_id2;
    logic [15:0] rf_write_data1, rf_write_data2, rf_read_data1, rf_read_data2;

    rf_port_arbiter #(.N_REQ(N), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_write_i(req_write),
        .req_reg_i(req_reg), .req_wdata_i(req_wdata),
        .req_grant_o(req_grant), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .init_done_o(init_done),
        .rf_rd1_o(rf_rd1), .rf_wn1_o(rf_wn1), .rf_reg_id1_o(rf_reg_id1), .rf_write_data1_o(rf_write_data1),
        .rf_rd2_o(rf_rd2), .rf_wn2_o(rf_wn2), .rf_reg_id2_o(rf_reg_id2), .rf_write_data2_o(rf_write_data2),
        .rf_read_data1_i(rf_read_data1), .rf_read_data2_i(rf_read_data2)
    );

    always #5 clk = ~clk;

    // Register file emulation: combinational read, write at the edge.
    logic [15:0] rf_mem [16];
    assign rf_read_data1 = rf_mem[rf_reg_id1];
    assign rf_read_data2 = rf_mem[rf_reg_id2];
    always @(posedge clk) if (rf_wn2) rf_mem[rf_reg_id2] <= rf_write_data2;

    int n_cmp = 0, n_err = 0, cyc_cnt = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        rst_q   <= reset_n;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    typedef struct { int rq; int cyc; logic [15:0] d; } exp_t;
    exp_t sb[$];

    // Reference model: spec-level arbitration and register contents.
    bit          model_on = 1'b0;
    int          m_rr = 0;
    logic [N-1:0] m_gnt = '0;
    logic [15:0] model_mem [16];

    always @(negedge clk) begin
        logic [N-1:0] eg;
        bit a_free, b_free, wq;
        int last, i, wq_r;
        logic [15:0] wq_d;
        exp_t e;
        if (model_on && reset_n) begin
            eg = '0; a_free = 1; b_free = 1; last = -1; wq = 0; wq_r = 0; wq_d = '0;
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (req_valid[i]) begin
                    if (req_write[i]) begin
                        if (b_free) begin
                            b_free = 0; eg[i] = 1; last = i;
                            wq = 1; wq_r = int'(req_reg[i]); wq_d = req_wdata[i];
                        end
                    end else if (a_free || b_free) begin
                        if (a_free) a_free = 0; else b_free = 0;
                        eg[i] = 1; last = i;
                        e.rq = i; e.cyc = cyc_cnt; e.d = model_mem[req_reg[i]];
                        sb.push_back(e);
                    end
                end
            end
            check("grant", 32'(req_grant), 32'(eg));
            check("portA_busy", 32'(rf_rd1), 32'(!a_free));
            check("portB_busy", 32'(rf_rd2 | rf_wn2), 32'(!b_free));
            check("portA_readonly", {15'd0, rf_wn1, rf_write_data1}, 32'd0);
            if (wq) model_mem[wq_r] = wq_d;
            if (last >= 0) m_rr = (last + 1) % N;
            m_gnt = eg;
        end else begin
            m_gnt = '0;
        end
    end

    // Response monitor: pops entries granted in the previous cycle.
    logic [15:0] last_d [N];
    initial for (int i = 0; i < N; i++) last_d[i] = '0;
    always @(negedge clk) begin
        logic [N-1:0] ev;
        logic [15:0]  ed [N];
        ev = '0;
        for (int i = 0; i < N; i++) ed[i] = '0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc < cyc_cnt) begin
                if (sb[j].cyc == cyc_cnt - 1) begin
                    ev[sb[j].rq] = 1'b1;
                    ed[sb[j].rq] = sb[j].d;
                end
                sb.delete(j);
            end
        end
        if (!rst_q) begin
            ev = '0;
            for (int i = 0; i < N; i++) last_d[i] = '0;
        end
        check("resp_valid", 32'(resp_valid), 32'(ev));
        for (int i = 0; i < N; i++) begin
            if (ev[i]) last_d[i] = ed[i];
            check("resp_rdata", 32'(resp_rdata[i]), 32'(last_d[i]));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int r, input logic [15:0] d);
        req_valid[i] = v; req_write[i] = w; req_reg[i] = 4'(r); req_wdata[i] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 16'h0);
    endtask

    task automatic clear_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("clr_wn2", 32'(rf_wn2), 32'd1);
            check("clr_rd2", 32'(rf_rd2), 32'd0);
            check("clr_reg_id", 32'(rf_reg_id2), 32'(k));
            check("clr_wdata", 32'(rf_write_data2), 32'd0);
            check("clr_no_grant", 32'(req_grant), 32'd0);
            check("clr_init_done", 32'(init_done), 32'd0);
            step();
        end
    endtask

    task automatic start_model();
        for (int r = 0; r < 16; r++) model_mem[r] = '0;
        m_rr = 0;
        model_on = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf_mem[r] = 16'($urandom | 1);
        reset_n = 1'b0;
        idle_all();
        set_req(0, 1, 0, 7, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(req_grant), 32'd0);
        check("rst_strobes", {28'd0, rf_rd1, rf_wn1, rf_rd2, rf_wn2}, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Sweep r0..r15, then a pending read of r7 is served with the cleared value.
        clear_check(16);
        check("init_done_rise", 32'(init_done), 32'd1);
        start_model();
        @(negedge clk);
        check("first_grant", 32'(req_grant), 32'b0001);
        step();
        idle_all();

        // Requester 3 loads r1..r5 so the pointer ends at 0.
        for (int r = 1; r <= 5; r++) begin
            set_req(3, 1, 1, r, 16'(r * 16'h1111));
            step();
        end
        idle_all();
        step();

        // Four continuous readers: pairs {0,1}, {2,3} alternate.
        for (int i = 0; i < N; i++) set_req(i, 1, 0, i + 1, 16'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_pair", 32'(req_grant), (k % 2) ? 32'b1100 : 32'b0011);
            step();
        end
        idle_all();

        // Same-cycle write and read of r5: read sees the old value, next read sees BEEF.
        set_req(0, 1, 1, 5, 16'hBEEF);
        set_req(1, 1, 0, 5, 16'h0);
        @(negedge clk);
        check("wr_rd_grant", 32'(req_grant), 32'b0011);
        step();
        set_req(0, 0, 0, 0, 16'h0);
        @(negedge clk);
        check("rd_after_wr_grant", 32'(req_grant), 32'b0010);
        step();
        idle_all();
        @(negedge clk);
        check("beef_valid", 32'(resp_valid[1]), 32'd1);
        check("beef_data", 32'(resp_rdata[1]), 32'hBEEF);
        step();

        // Two writers and one reader: one write waits a cycle.
        set_req(0, 1, 1, 6, 16'hA0A0);
        set_req(1, 1, 1, 8, 16'hB1B1);
        set_req(2, 1, 0, 6, 16'h0);
        @(negedge clk);
        check("ww_r_grant", 32'(req_grant), 32'b0101);
        step();
        set_req(0, 0, 0, 0, 16'h0);
        set_req(2, 0, 0, 0, 16'h0);
        @(negedge clk);
        check("ww_r_second", 32'(req_grant), 32'b0010);
        step();
        idle_all();

        // Lone reader: port A every cycle, port B idle.
        set_req(2, 1, 0, 3, 16'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("solo_grant", 32'(req_grant), 32'b0100);
            check("solo_portB_idle", {30'd0, rf_rd2, rf_wn2}, 32'd0);
            step();
        end
        idle_all();
        set_req(3, 1, 1, 7, 16'h1234);
        step();
        idle_all();
        repeat (3) step();

        // Random traffic, each requester holding its request until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_gnt[i]) begin
                    set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                            int'($urandom_range(0, 7)), 16'($urandom));
                end
            end
            step();
        end
        idle_all();
        repeat (3) step();

        // Reset in the middle of the sweep restarts it from r0.
        model_on = 1'b0;
        sb.delete();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        clear_check(8);
        reset_n = 1'b0;
        @(negedge clk);
        check("midclr_wn2_drop", 32'(rf_wn2), 32'd0);
        check("midclr_id_drop", 32'(rf_reg_id2), 32'd0);
        check("midclr_init", 32'(init_done), 32'd0);
        step();
        reset_n = 1'b1;
        clear_check(16);
        check("init_done_again", 32'(init_done), 32'd1);
        start_model();
        set_req(0, 1, 0, 7, 16'h0);
        step();
        idle_all();
        @(negedge clk);
        check("r7_cleared_valid", 32'(resp_valid[0]), 32'd1);
        check("r7_cleared_data", 32'(resp_rdata[0]), 32'd0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Shares the 16-entry × 16-bit two-port register file among N_REQ requesters, e.g. decode, ALU writeback, load/store and debug. Each cycle it grants up to two requests in round-robin order. It maps granted requests onto the register file's rd/wn strobes, reg ids and write data, and registers read data back to each requester. After reset it runs an optional clear sequence that zeroes all 16 registers before any request is served.

## Interface
- N_REQ, 4: number of requesters (2..8).
- CLEAR_ON_RESET, 1: 1 = zero r0..r15 after reset; 0 = go straight to service.
- clk  in  1  system clock, all state on posedge.
- reset  in  1  reset is synchronous and active-low.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_reg  in  4*N_REQ  register id; requester i uses bits [4i+3:4i].
- req_wdata  in  16*N_REQ  write data; requester i uses bits [16i+15:16i].
- req_grant  out  N_REQ  combinational grant; the request is consumed this cycle.
- resp_valid  out  N_REQ  registered one-cycle pulse carrying read data.
- resp_rdata  out  16*N_REQ  registered read data; held until that requester's next read response.
- init_done  out  1  high once the clear sequence finishes; stays high until reset.
- rf_rd1, rf_wn1, rf_reg_id1, rf_write_data1  out  1,1,4,16  port A controls. Port A is read-only: rf_wn1 = 0 and rf_write_data1 = 0 always.
- rf_rd2, rf_wn2, rf_reg_id2, rf_write_data2  out  1,1,4,16  port B controls. Port B serves a read or a write.
- rf_read_data1, rf_read_data2  in  16  combinational read data from the register file.

## Operation
- FSM states: CLEAR, RUN.
  - Reset low: state = CLEAR, clr_cnt = 0, rr_ptr = 0, resp_valid = 0, resp_rdata = 0, init_done = 0.
  - While reset is low, all rf_* strobes and req_grant are forced to 0 combinationally.
- CLEAR (CLEAR_ON_RESET = 1):
  - Each cycle: rf_wn2 = 1, rf_rd2 = 0, rf_reg_id2 = clr_cnt, rf_write_data2 = 0; clr_cnt increments.
  - After the write to r15 (clr_cnt = 15), go to RUN and set init_done.
  - No grants are issued in CLEAR.
  - With CLEAR_ON_RESET = 0, CLEAR lasts zero cycles: RUN and init_done = 1 on the first cycle after reset deasserts.
- RUN arbitration (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, …, wrapping mod N_REQ.
  - Valid read: takes port A if free, otherwise port B if free, otherwise waits.
  - Valid write: takes port B if free, otherwise waits. At most one write per cycle.
  - The scan stops when both ports are taken or all requesters have been checked.
  - A waiting request does not block later requesters; e.g. a write blocked on port B does not stop a following read from taking port A.
- Port drive:
  - Granted read on port A: rf_rd1 = 1, rf_reg_id1 = reg.
  - Granted read on port B: rf_rd2 = 1, rf_wn2 = 0, rf_reg_id2 = reg.
  - Granted write on port B: rf_rd2 = 0, rf_wn2 = 1, rf_reg_id2 = reg, rf_write_data2 = wdata.
  - Idle port: rd = 0, wn = 0, id = 0, data = 0.
- rr_ptr update: at each edge with at least one grant, rr_ptr <= (highest-priority-order granted index + 1) mod N_REQ, i.e. one past the last grant in scan order. Unchanged if there is no grant.
- Same-cycle read and write of the same register: the read returns the old value, because the write lands at the edge.
- Requesters hold valid and payload stable until granted. req_valid must not depend combinationally on req_grant.

## Timing
- Grant in cycle T, the same cycle as the valid request.
- Read data: resp_valid[i] = 1 and resp_rdata[i] = the old register value in cycle T+1, for exactly one cycle.
- Writes have no response. The new value is visible to reads granted from T+1.
- Throughput: up to 2 reads per cycle, or 1 read + 1 write.
- Reset-to-service latency: 17 cycles with CLEAR_ON_RESET = 1; 1 cycle with CLEAR_ON_RESET = 0.
- Reset asserted mid-CLEAR or mid-RUN:
  - Pending responses are discarded and resp_valid drops the next cycle.
  - The clear sequence restarts from r0.
- A requester granted twice in consecutive cycles gets back-to-back resp_valid pulses.

## Test plan
- Reset, CLEAR_ON_RESET = 1: r0..r15 written with 0 in cycles 1..16 on port B, in order; init_done rises at cycle 17; a read of r7 then returns 0x0000 one cycle after grant.
- All 4 requesters read r1..r4 continuously from rr_ptr = 0: grants go {0,1}, {2,3}, {0,1}, …; each requester gets resp_valid every 2nd cycle with its register's value.
- Requester 0 writes r5 = 0xBEEF while requester 1 reads r5 in the same cycle: both granted; requester 1 gets the old value at T+1; a read of r5 granted at T+1 returns 0xBEEF at T+2.
- Requesters 0 and 1 both write while requester 2 reads: requester 0 gets port B and requester 2 gets port A; requester 1 waits and is granted the next cycle because rr_ptr advanced.
- A single requester holding valid reads continuously: granted every cycle on port A; port B stays idle (rd2 = wn2 = 0).
- Reset driven low at cycle 8 of CLEAR: strobes drop at once; after release the clear restarts at r0 and init_done rises 16 cycles later.
